sipo_rx: RTL and testbench

- Serial-to-parallel receiver that sits directly downstream of the 4-bit parallel-in/serial-out shifter.
- Samples the serial bitstream on a bit strobe and assembles WIDTH-bit words, MSB first. The upstream shifter emits d[3] first.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags overrun and framing errors.

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_out_reg.sv | 38 +++
 rtl/sipo_rx.sv | 132 +++++++++++++
 tb/tb_sipo_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, defaults and sizing helper for the serial receiver
package sipo_pkg;

    // Receiver control state: waiting for a first bit, or assembling a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Matches the 4-bit parallel-in/serial-out shifter feeding this block.
    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// rtl/sipo_out_reg.sv - parallel word holding register with valid/ready and overrun
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun
);

    // A consumer handshake on the same cycle as a new word frees the slot,
    // so the new word only gets dropped when the old one is still pending.
    logic slot_free;
    assign slot_free = !q_valid || q_ready;

    // Hold, replace or drop words; overrun is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (load) begin
            if (slot_free) begin
                q       <= data;
                q_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (q_valid && q_ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-to-parallel receiver, MSB first, with framing/overrun flags
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit FREE_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    // Only the bits ahead of the final one need storing; the last bit is
    // concatenated straight into the completed word.
    localparam int SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   sr;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic            word_done;
    logic            seen_word;
    logic            load_first;
    logic            restart;
    logic            shift_bit;
    logic            complete;

    assign shifted  = {sr, sin};
    assign complete = shift_bit && (cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-bit actions; sin and sync only matter under sin_en.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        restart    = 1'b0;
        shift_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (sin_en && (sync || (FREE_RUN && seen_word))) begin
                    load_first = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_en) begin
                    if (sync) begin
                        restart = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
                        if (cnt == LAST) begin
                            state_next = FREE_RUN ? SHIFT : IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Shift register, bit count, completion pipeline stage and framing flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            word      <= '0;
            word_done <= 1'b0;
            seen_word <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= complete;
            if (load_first || restart) begin
                // A fresh first bit starts from a clean register so no bits of
                // an abandoned word can leak into the next one.
                sr  <= SW'(sin);
                cnt <= CW'(1);
            end else if (shift_bit) begin
                if (complete) begin
                    word      <= shifted;
                    seen_word <= 1'b1;
                    sr        <= '0;
                    cnt       <= '0;
                end else begin
                    sr  <= shifted[SW-1:0];
                    cnt <= cnt + CW'(1);
                end
            end
            if (restart) begin
                frame_err <= 1'b1;
            end
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (word_done),
        .data    (word),
        .q_ready (q_ready),
        .q       (q),
        .q_valid (q_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - scoreboard bench for sipo_rx, FREE_RUN=0 and FREE_RUN=1 instances
module tb_sipo_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       sin0 = 1'b0, en0 = 1'b0, sync0 = 1'b0, rdy0 = 1'b0;
    logic [3:0] q0;
    logic       qv0, ovr0, ferr0, busy0;

    logic       sin1 = 1'b0, en1 = 1'b0, sync1 = 1'b0, rdy1 = 1'b0;
    logic [3:0] q1;
    logic       qv1, ovr1, ferr1, busy1;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp0[$];
    logic [3:0] exp1[$];

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .FREE_RUN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sin(sin0), .sin_en(en0), .sync(sync0),
        .q(q0), .q_valid(qv0), .q_ready(rdy0),
        .overrun(ovr0), .frame_err(ferr0), .busy(busy0)
    );

    sipo_rx #(.WIDTH(4), .FREE_RUN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sin(sin1), .sin_en(en1), .sync(sync1),
        .q(q1), .q_valid(qv1), .q_ready(rdy1),
        .overrun(ovr1), .frame_err(ferr1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a word is newly presented when q_valid is high and the slot
    // was empty or handshaken at the previous edge.
    logic pv0 = 1'b0, phs0 = 1'b0, pv1 = 1'b0, phs1 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0; phs0 = 1'b0;
        end else begin
            if (qv0 && (!pv0 || phs0)) begin
                if (exp0.size() == 0) begin
                    check("dut0 unexpected word", {28'h0, q0}, 32'hdead);
                end else begin
                    check("dut0 word", {28'h0, q0}, {28'h0, exp0.pop_front()});
                end
            end
            pv0 = qv0; phs0 = qv0 && rdy0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv1 = 1'b0; phs1 = 1'b0;
        end else begin
            if (qv1 && (!pv1 || phs1)) begin
                if (exp1.size() == 0) begin
                    check("dut1 unexpected word", {28'h0, q1}, 32'hdead);
                end else begin
                    check("dut1 word", {28'h0, q1}, {28'h0, exp1.pop_front()});
                end
            end
            pv1 = qv1; phs1 = qv1 && rdy1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic strobe(input int d, input logic b, input logic s);
        if (d == 0) begin sin0 = b; sync0 = s; en0 = 1'b1; end
        else        begin sin1 = b; sync1 = s; en1 = 1'b1; end
        tick(1);
        if (d == 0) begin en0 = 1'b0; sync0 = 1'b0; end
        else        begin en1 = 1'b0; sync1 = 1'b0; end
    endtask

    // Idle cycle between strobes; optionally wiggle sin/sync while ungated.
    task automatic gap(input int d, input bit junk);
        if (junk) begin
            if (d == 0) begin sin0 = ~sin0; sync0 = 1'b1; end
            else        begin sin1 = ~sin1; sync1 = 1'b1; end
        end
        tick(1);
        if (d == 0) sync0 = 1'b0; else sync1 = 1'b0;
    endtask

    task automatic send_word(input int d, input logic [3:0] w, input bit junk);
        for (int i = 3; i >= 0; i--) begin
            strobe(d, w[i], i == 3);
            gap(d, junk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        check("reset dut0 outputs", {24'h0, q0, qv0, ovr0, ferr0, busy0}, 32'h0);
        check("reset dut1 outputs", {24'h0, q1, qv1, ovr1, ferr1, busy1}, 32'h0);
        check("reset leftover expected words", exp0.size() + exp1.size(), 0);
        exp0.delete();
        exp1.delete();
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        do_reset();

        // 1: basic word, exact latency, busy drops after the last bit
        rdy0 = 1'b0;
        exp0.push_back(4'b1011);
        strobe(0, 1'b1, 1'b1);
        check("s1 busy mid-word", busy0, 1);
        gap(0, 0); strobe(0, 1'b0, 1'b0);
        gap(0, 0); strobe(0, 1'b1, 1'b0);
        gap(0, 0); strobe(0, 1'b1, 1'b0);
        check("s1 q_valid not yet", qv0, 0);
        check("s1 busy after word", busy0, 0);
        tick(1);
        check("s1 q_valid one cycle later", qv0, 1);
        check("s1 q", q0, 4'b1011);
        rdy0 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        check("s1 q_valid cleared by ready", qv0, 0);

        // 2: FREE_RUN back-to-back words with a ready consumer
        rdy1 = 1'b1;
        exp1.push_back(4'b1100);
        exp1.push_back(4'b0110);
        strobe(1, 1'b1, 1'b1); gap(1, 0);
        strobe(1, 1'b1, 1'b0); gap(1, 0);
        strobe(1, 1'b0, 1'b0); gap(1, 0);
        strobe(1, 1'b0, 1'b0); gap(1, 0);
        strobe(1, 1'b0, 1'b0); gap(1, 0);
        strobe(1, 1'b1, 1'b0); gap(1, 0);
        strobe(1, 1'b1, 1'b0); gap(1, 0);
        strobe(1, 1'b0, 1'b0); gap(1, 0);
        tick(3);
        check("s2 overrun", ovr1, 0);
        check("s2 last q", q1, 4'b0110);
        check("s2 busy stays in free-run", busy1, 1);
        check("s2 words all seen", exp1.size(), 0);

        // 3: overrun drops the second word and is sticky
        do_reset();
        rdy0 = 1'b0;
        exp0.push_back(4'b1001);
        send_word(0, 4'b1001, 0);
        tick(2);
        check("s3 overrun before", ovr0, 0);
        send_word(0, 4'b0101, 0);
        tick(2);
        check("s3 q kept", q0, 4'b1001);
        check("s3 q_valid held", qv0, 1);
        check("s3 overrun set", ovr0, 1);
        rdy0 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        check("s3 q_valid cleared", qv0, 0);
        check("s3 overrun sticky", ovr0, 1);

        // 4: sync mid-word restarts the word and flags framing
        do_reset();
        rdy0 = 1'b1;
        exp0.push_back(4'b0010);
        strobe(0, 1'b1, 1'b1); gap(0, 0);
        strobe(0, 1'b1, 1'b0); gap(0, 0);
        check("s4 frame_err before", ferr0, 0);
        send_word(0, 4'b0010, 0);
        tick(3);
        check("s4 frame_err", ferr0, 1);
        check("s4 q", q0, 4'b0010);
        rdy0 = 1'b0;

        // 5: asynchronous reset mid-word
        do_reset();
        strobe(0, 1'b1, 1'b1); gap(0, 0);
        strobe(0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("s5 outputs in reset", {24'h0, q0, qv0, ovr0, ferr0, busy0}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        exp0.push_back(4'b0111);
        send_word(0, 4'b0111, 0);
        tick(2);
        check("s5 q", q0, 4'b0111);
        check("s5 no frame_err", ferr0, 0);
        check("s5 busy", busy0, 0);

        // 6: sin/sync ignored without sin_en
        do_reset();
        exp0.push_back(4'b1110);
        send_word(0, 4'b1110, 1);
        tick(2);
        check("s6 q", q0, 4'b1110);
        check("s6 frame_err", ferr0, 0);

        tick(3);
        check("dut0 words all seen", exp0.size(), 0);
        check("dut1 words all seen", exp1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
